// File: rtl/bram18k_pkg.sv
// bram18k_pkg: mode constants and depth helper shared by the BRAM18K FIFO controller.
package bram18k_pkg;
   localparam int BRAM18K_X18_AW = 10;
   localparam int BRAM18K_X18_DW = 18;
   localparam int BRAM18K_X9_AW  = 11;
   localparam int BRAM18K_X9_DW  = 9;
   function automatic int bram18k_depth(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/bram18k_fifo_flags.sv
// bram18k_fifo_flags: occupancy counter and registered full/empty/almost flags.
module bram18k_fifo_flags
   import bram18k_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int AF_MARGIN  = 4,
   parameter int AE_MARGIN  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push_acc,
   input  logic                pop_acc,
   output logic [ADDR_WIDTH:0] count,
   output logic                full,
   output logic                empty,
   output logic                almost_full,
   output logic                almost_empty
);
   localparam int DEPTH = bram18k_depth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] FULL_L = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_L   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_WIDTH:0] AE_L   = (ADDR_WIDTH+1)'(AE_MARGIN);
   logic [ADDR_WIDTH:0] count_d;
   always_comb
      count_d = (push_acc & ~pop_acc) ? count + ONE :
                (pop_acc & ~push_acc) ? count - ONE : count;
   // Flags come from the next count so they line up with count after the edge.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         count        <= count_d;
         full         <= count_d == FULL_L;
         empty        <= count_d == '0;
         almost_full  <= count_d >= AF_L;
         almost_empty <= count_d <= AE_L;
      end
endmodule

// File: rtl/bram18k_fifo_ctrl.sv
// bram18k_fifo_ctrl: single-clock FIFO controller for one DPRAM_18K_BLK (port 1 write, port 2 read).
// Defining BRAM18K_FIFO_ERR_EN adds sticky overflow_o/underflow_o outputs.
module bram18k_fifo_ctrl
   import bram18k_pkg::*;
#(
   parameter int ADDR_WIDTH = BRAM18K_X18_AW,
   parameter int DATA_WIDTH = BRAM18K_X18_DW,
   parameter int AF_MARGIN  = 4,
   parameter int AE_MARGIN  = 4
) (
   input  logic                  CLK_i,
   input  logic                  RESET_ni,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] pop_data_o,
   output logic                  pop_valid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  ram_wen1_o,
   output logic                  ram_ren1_o,
   output logic                  ram_wen2_o,
   output logic                  ram_ren2_o,
   output logic [ADDR_WIDTH-1:0] ram_wr1_addr_o,
   output logic [ADDR_WIDTH-1:0] ram_rd2_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata1_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata2_i
`ifdef BRAM18K_FIFO_ERR_EN
  ,output logic                  overflow_o,
   output logic                  underflow_o
`endif
);
   localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
   logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
   logic push_acc, pop_acc;
   // Reset gating keeps the RAM quiet while RESET_ni is held low.
   assign push_acc       = push_i & ~full_o & RESET_ni;
   assign pop_acc        = pop_i & ~empty_o & RESET_ni;
   assign ram_wen1_o     = push_acc;
   assign ram_ren2_o     = pop_acc;
   assign ram_ren1_o     = 1'b0;
   assign ram_wen2_o     = 1'b0;
   assign ram_wr1_addr_o = wr_ptr[ADDR_WIDTH-1:0];
   assign ram_rd2_addr_o = rd_ptr[ADDR_WIDTH-1:0];
   assign ram_wdata1_o   = push_data_i;
   assign pop_data_o     = ram_rdata2_i;
   always_ff @(posedge CLK_i or negedge RESET_ni)
      if (!RESET_ni) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pop_valid_o <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + ONE;
         if (pop_acc) rd_ptr <= rd_ptr + ONE;
         pop_valid_o <= pop_acc;
      end
`ifdef BRAM18K_FIFO_ERR_EN
   always_ff @(posedge CLK_i or negedge RESET_ni)
      if (!RESET_ni) begin
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else begin
         overflow_o  <= overflow_o | (push_i & full_o);
         underflow_o <= underflow_o | (pop_i & empty_o);
      end
`endif
   bram18k_fifo_flags #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .AF_MARGIN (AF_MARGIN),
      .AE_MARGIN (AE_MARGIN)
   ) u_flags (
      .clk         (CLK_i),
      .rst_n       (RESET_ni),
      .push_acc    (push_acc),
      .pop_acc     (pop_acc),
      .count       (count_o),
      .full        (full_o),
      .empty       (empty_o),
      .almost_full (almost_full_o),
      .almost_empty(almost_empty_o)
   );
endmodule

// File: tb/tb_bram18k_fifo_ctrl.sv
// tb_bram18k_fifo_ctrl: checks 18x1024 and 9x2048 instances against a queue model with RAM models attached.
module tb_bram18k_fifo_ctrl;
   logic clk = 1'b0;
   logic RESET_ni = 1'b0;
   logic push = 1'b0, pop = 1'b0, sel = 1'b0;
   logic [17:0] data = '0;
   always #5 clk = ~clk;

   logic [17:0] pd18, wd18, rd18;
   logic pv18, f18, e18, af18, ae18, wen1_18, ren1_18, wen2_18, ren2_18, ov18, un18;
   logic [10:0] c18;
   logic [9:0] wa18, ra18;
   logic [8:0] pd9, wd9, rd9;
   logic pv9, f9, e9, af9, ae9, wen1_9, ren1_9, wen2_9, ren2_9, ov9, un9;
   logic [11:0] c9;
   logic [10:0] wa9, ra9;

   bram18k_fifo_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(18)) u18 (
      .CLK_i(clk), .RESET_ni(RESET_ni), .push_i(push & ~sel), .push_data_i(data),
      .pop_i(pop & ~sel), .pop_data_o(pd18), .pop_valid_o(pv18), .full_o(f18),
      .empty_o(e18), .almost_full_o(af18), .almost_empty_o(ae18), .count_o(c18),
      .ram_wen1_o(wen1_18), .ram_ren1_o(ren1_18), .ram_wen2_o(wen2_18), .ram_ren2_o(ren2_18),
      .ram_wr1_addr_o(wa18), .ram_rd2_addr_o(ra18), .ram_wdata1_o(wd18), .ram_rdata2_i(rd18)
`ifdef BRAM18K_FIFO_ERR_EN
     ,.overflow_o(ov18), .underflow_o(un18)
`endif
   );
   bram18k_fifo_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(9)) u9 (
      .CLK_i(clk), .RESET_ni(RESET_ni), .push_i(push & sel), .push_data_i(data[8:0]),
      .pop_i(pop & sel), .pop_data_o(pd9), .pop_valid_o(pv9), .full_o(f9),
      .empty_o(e9), .almost_full_o(af9), .almost_empty_o(ae9), .count_o(c9),
      .ram_wen1_o(wen1_9), .ram_ren1_o(ren1_9), .ram_wen2_o(wen2_9), .ram_ren2_o(ren2_9),
      .ram_wr1_addr_o(wa9), .ram_rd2_addr_o(ra9), .ram_wdata1_o(wd9), .ram_rdata2_i(rd9)
`ifdef BRAM18K_FIFO_ERR_EN
     ,.overflow_o(ov9), .underflow_o(un9)
`endif
   );
`ifndef BRAM18K_FIFO_ERR_EN
   assign ov18 = 1'b0;
   assign un18 = 1'b0;
   assign ov9  = 1'b0;
   assign un9  = 1'b0;
`endif

   logic [17:0] mem18 [1024];
   logic [8:0]  mem9  [2048];
   always @(posedge clk) begin
      if (wen1_18) mem18[wa18] <= wd18;
      if (ren2_18) rd18 <= mem18[ra18];
      if (wen1_9) mem9[wa9] <= wd9;
      if (ren2_9) rd9 <= mem9[ra9];
   end

   wire [17:0] o_pd   = sel ? {9'b0, pd9} : pd18;
   wire [17:0] o_wd   = sel ? {9'b0, wd9} : wd18;
   wire [11:0] o_cnt  = sel ? c9 : {1'b0, c18};
   wire [10:0] o_wa   = sel ? wa9 : {1'b0, wa18};
   wire [10:0] o_ra   = sel ? ra9 : {1'b0, ra18};
   wire o_pv = sel ? pv9 : pv18;
   wire o_f  = sel ? f9 : f18;
   wire o_e  = sel ? e9 : e18;
   wire o_af = sel ? af9 : af18;
   wire o_ae = sel ? ae9 : ae18;
   wire o_wen = sel ? wen1_9 : wen1_18;
   wire o_ren = sel ? ren2_9 : ren2_18;
   wire o_tie = sel ? (ren1_9 | wen2_9) : (ren1_18 | wen2_18);
   wire o_ov = sel ? ov9 : ov18;
   wire o_un = sel ? un9 : un18;

   logic [17:0] q [$];
   int wr_cnt = 0, rd_cnt = 0, depth = 1024;
   logic [17:0] mask = 18'h3ffff;
   logic ovf_e = 1'b0, udf_e = 1'b0;
   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("count", o_cnt, q.size());
      chk("empty", o_e, q.size() == 0);
      chk("full", o_f, q.size() == depth);
      chk("almost_full", o_af, q.size() >= depth - 4);
      chk("almost_empty", o_ae, q.size() <= 4);
`ifdef BRAM18K_FIFO_ERR_EN
      chk("overflow", o_ov, ovf_e);
      chk("underflow", o_un, udf_e);
`endif
   endtask

   task automatic model_reset();
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
      ovf_e = 1'b0;
      udf_e = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      RESET_ni = 1'b0;
      push = 1'b0;
      pop = 1'b0;
      repeat (2) @(negedge clk);
      RESET_ni = 1'b1;
      model_reset();
      #1;
      chk("reset_pv", o_pv, 1'b0);
      chk_state();
   endtask

   task automatic step(input logic ps, input logic pp, input logic [17:0] d);
      logic pa, po;
      logic [17:0] exp_d;
      @(negedge clk);
      push = ps;
      pop = pp;
      data = d & mask;
      #1;
      pa = ps && (q.size() < depth);
      po = pp && (q.size() > 0);
      chk("ram_wen1", o_wen, pa);
      chk("ram_ren2", o_ren, po);
      chk("ram_tied", o_tie, 1'b0);
      chk("ram_wdata1", o_wd, data);
      if (pa) chk("ram_wr1_addr", o_wa, wr_cnt % depth);
      if (po) chk("ram_rd2_addr", o_ra, rd_cnt % depth);
      @(posedge clk);
      #1;
      exp_d = '0;
      if (po) begin
         exp_d = q.pop_front();
         rd_cnt++;
      end
      if (pa) begin
         q.push_back(data);
         wr_cnt++;
      end
      if (ps && !pa) ovf_e = 1'b1;
      if (pp && !po) udf_e = 1'b1;
      chk("pop_valid", o_pv, po);
      if (po) chk("pop_data", o_pd, exp_d);
      chk_state();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      repeat (3) step(1'b0, 1'b0, 18'h0);
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 18'(i));
      repeat (5) step(1'b0, 1'b1, 18'h0);
      step(1'b1, 1'b1, 18'h00abc);
      step(1'b1, 1'b0, 18'h00def);
      step(1'b1, 1'b0, 18'h01234);
      step(1'b1, 1'b1, 18'h05678);
      repeat (4) step(1'b0, 1'b1, 18'h0);
      repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 18'($urandom()));
      while (q.size() > 0) step(1'b0, 1'b1, 18'h0);
      repeat (1024) step(1'b1, 1'b0, 18'($urandom()));
      step(1'b1, 1'b0, 18'h3ffff);
      step(1'b1, 1'b1, 18'h2aaaa);
      step(1'b1, 1'b0, 18'h15555);
      while (q.size() > 0) step(1'b0, 1'b1, 18'h0);
      step(1'b0, 1'b1, 18'h0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 18'($urandom()));
      step(1'b0, 1'b1, 18'h0);
      push = 1'b1;
      pop = 1'b1;
      #2;
      RESET_ni = 1'b0;
      #1;
      chk("async_count", o_cnt, 0);
      chk("async_pv", o_pv, 1'b0);
      chk("async_empty", o_e, 1'b1);
      chk("async_aempty", o_ae, 1'b1);
      chk("async_wen", o_wen, 1'b0);
      chk("async_ren", o_ren, 1'b0);
      @(negedge clk);
      @(negedge clk);
      push = 1'b0;
      pop = 1'b0;
      RESET_ni = 1'b1;
      model_reset();
      step(1'b1, 1'b0, 18'h00077);
      step(1'b0, 1'b1, 18'h0);
      sel = 1'b1;
      depth = 2048;
      mask = 18'h001ff;
      do_reset();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 18'($urandom()));
      repeat (3000) step(1'b1, 1'b1, 18'($urandom()));
      while (q.size() > 0) step(1'b0, 1'b1, 18'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
